// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the MW writeback stage always wins the port.
// Mult/div results wait in an in-order holding FIFO and drain in free slots.
// When a buffered result starves, the block asks the pipeline for a bubble.
// It also flags RAW hazards on buffered destinations and kills stale WAW entries.
//
// Ports:
//   clock, reset_n          rising-edge clock; asynchronous active-low reset
//   pipe_we/reg/data        MW stage write request
//   md_valid/reg/data       mult/div result offered to the FIFO
//   md_ready                the FIFO can accept a result this cycle
//   rs_a, rs_b              decode-stage source registers
//   hazard                  a source matches a live buffered destination
//   stall_pipe              request a pipeline bubble so the FIFO can drain
//   rf_we/reg/data          register file write port
//   pending_cnt             number of entries currently buffered
module wb_port_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4,
    parameter int REG_W    = 5,
    parameter int DATA_W   = 32
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         pipe_we,
    input  logic [REG_W-1:0]             pipe_reg,
    input  logic [DATA_W-1:0]            pipe_data,
    input  logic                         md_valid,
    input  logic [REG_W-1:0]             md_reg,
    input  logic [DATA_W-1:0]            md_data,
    output logic                         md_ready,
    input  logic [REG_W-1:0]             rs_a,
    input  logic [REG_W-1:0]             rs_b,
    output logic                         hazard,
    output logic                         stall_pipe,
    output logic                         rf_we,
    output logic [REG_W-1:0]             rf_reg,
    output logic [DATA_W-1:0]            rf_data,
    output logic [$clog2(DEPTH+1)-1:0]   pending_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int WW = $clog2(MAX_WAIT+1);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FORCE
    } arbState;

    logic [REG_W-1:0]  entReg  [DEPTH];
    logic [DATA_W-1:0] entData [DEPTH];
    logic [DEPTH-1:0]  entLive;
    logic [PW-1:0]     rdPtr;
    logic [PW-1:0]     wrPtr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     countNext;
    logic [WW-1:0]     waitCnt;
    logic [WW-1:0]     waitNext;
    arbState           state;
    logic              stallReg;

    logic pipeSlot;
    logic notEmpty;
    logic headLive;
    logic pop;
    logic pushAcc;
    logic pushKeep;

    // A write to r0 is architecturally a no-op, so it leaves the port free.
    assign pipeSlot = pipe_we && (pipe_reg != '0);
    assign notEmpty = (count != '0);
    assign headLive = notEmpty && entLive[rdPtr];

    // A dead head is discarded even while the pipeline owns the port.
    assign pop      = notEmpty && (!entLive[rdPtr] || !pipeSlot);

    assign md_ready = (count < CW'(DEPTH));
    assign pushAcc  = md_valid && md_ready;
    // r0 results are accepted but never stored.
    assign pushKeep = pushAcc && (md_reg != '0);

    assign pending_cnt = count;
    assign stall_pipe  = stallReg;

    always_comb begin
        countNext = count;
        if (pushKeep && !pop) begin
            countNext = count + 1'b1;
        end else if (!pushKeep && pop) begin
            countNext = count - 1'b1;
        end
    end

    always_comb begin
        waitNext = waitCnt;
        if (pop || !notEmpty) begin
            waitNext = '0;
        end else if (waitCnt < WW'(MAX_WAIT)) begin
            waitNext = waitCnt + 1'b1;
        end
    end

    always_comb begin
        rf_we   = 1'b0;
        rf_reg  = '0;
        rf_data = '0;
        if (pipeSlot) begin
            rf_we   = 1'b1;
            rf_reg  = pipe_reg;
            rf_data = pipe_data;
        end else if (headLive) begin
            rf_we   = 1'b1;
            rf_reg  = entReg[rdPtr];
            rf_data = entData[rdPtr];
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entLive[i] &&
                (((rs_a != '0) && (entReg[i] == rs_a)) ||
                 ((rs_b != '0) && (entReg[i] == rs_b)))) begin
                hazard = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
            waitCnt <= '0;
            entLive <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entReg[i]  <= '0;
                entData[i] <= '0;
            end
        end else begin
            count   <= countNext;
            waitCnt <= waitNext;
            // Older entries to the same register are now stale.
            if (pipeSlot) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (entLive[i] && (entReg[i] == pipe_reg)) begin
                        entLive[i] <= 1'b0;
                    end
                end
            end
            if (pop) begin
                entLive[rdPtr] <= 1'b0;
                rdPtr          <= rdPtr + 1'b1;
            end
            // Written last so a same-cycle push of pipe_reg stays live.
            if (pushKeep) begin
                entLive[wrPtr] <= 1'b1;
                entReg[wrPtr]  <= md_reg;
                entData[wrPtr] <= md_data;
                wrPtr          <= wrPtr + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            stallReg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pushKeep) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (countNext == '0) begin
                        state <= IDLE;
                    end else if (waitNext == WW'(MAX_WAIT)) begin
                        state    <= FORCE;
                        stallReg <= 1'b1;
                    end
                end
                FORCE: begin
                    if (pop) begin
                        stallReg <= 1'b0;
                        state    <= (countNext == '0) ? IDLE : DRAIN;
                    end
                end
                default: begin
                    state    <= IDLE;
                    stallReg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus random traffic.
// A queue-based reference model feeds a per-cycle expectation scoreboard.
module tb_wb_port_arbiter;

    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        pipe_we = 1'b0;
    logic [4:0]  pipe_reg = '0;
    logic [31:0] pipe_data = '0;
    logic        md_valid = 1'b0;
    logic [4:0]  md_reg = '0;
    logic [31:0] md_data = '0;
    logic        md_ready;
    logic [4:0]  rs_a = '0;
    logic [4:0]  rs_b = '0;
    logic        hazard;
    logic        stall_pipe;
    logic        rf_we;
    logic [4:0]  rf_reg;
    logic [31:0] rf_data;
    logic [1:0]  pending_cnt;

    wb_port_arbiter #(
        .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .REG_W(5), .DATA_W(32)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .pipe_we(pipe_we), .pipe_reg(pipe_reg), .pipe_data(pipe_data),
        .md_valid(md_valid), .md_reg(md_reg), .md_data(md_data),
        .md_ready(md_ready), .rs_a(rs_a), .rs_b(rs_b),
        .hazard(hazard), .stall_pipe(stall_pipe),
        .rf_we(rf_we), .rf_reg(rf_reg), .rf_data(rf_data),
        .pending_cnt(pending_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          we;
        logic [4:0]  r;
        logic [31:0] d;
        bit          hz;
        bit          st;
        int          pend;
        bit          rdy;
    } exp_t;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        bit          live;
    } ent_t;

    exp_t sb[$];
    ent_t mq[$];
    int   age = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t",
                     name, act, expv, $time);
        end
    endtask

    // Monitor: every cycle the DUT presents its outputs, compare them
    // against the oldest queued expectation.
    always @(negedge clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("rf_we", 64'(rf_we), 64'(e.we));
            chk("rf_reg", 64'(rf_reg), 64'(e.r));
            chk("rf_data", 64'(rf_data), 64'(e.d));
            chk("hazard", 64'(hazard), 64'(e.hz));
            chk("stall_pipe", 64'(stall_pipe), 64'(e.st));
            chk("pending_cnt", 64'(pending_cnt), 64'(e.pend));
            chk("md_ready", 64'(md_ready), 64'(e.rdy));
        end
    end

    // One clock cycle of stimulus: drive inputs, predict outputs from the
    // model, then advance the model across the coming edge.
    task automatic cyc(input bit pwe, input logic [4:0] preg,
                       input logic [31:0] pdata, input bit mv,
                       input logic [4:0] mreg, input logic [31:0] mdata,
                       input logic [4:0] ra, input logic [4:0] rb);
        exp_t e;
        bit   slot;
        bit   popIt;
        int   sz;
        @(posedge clock);
        #1;
        pipe_we = pwe; pipe_reg = preg; pipe_data = pdata;
        md_valid = mv; md_reg = mreg; md_data = mdata;
        rs_a = ra; rs_b = rb;

        slot   = pwe && (preg != 0);
        sz     = mq.size();
        e.pend = sz;
        e.rdy  = (sz < DEPTH);
        e.st   = (age >= MAX_WAIT);
        e.we   = 1'b0; e.r = '0; e.d = '0;
        if (slot) begin
            e.we = 1'b1; e.r = preg; e.d = pdata;
        end else if (sz > 0 && mq[0].live) begin
            e.we = 1'b1; e.r = mq[0].r; e.d = mq[0].d;
        end
        e.hz = 1'b0;
        foreach (mq[i]) begin
            if (mq[i].live && ((ra != 0 && mq[i].r == ra) ||
                               (rb != 0 && mq[i].r == rb)))
                e.hz = 1'b1;
        end
        sb.push_back(e);

        popIt = (sz > 0) && (!mq[0].live || !slot);
        if (popIt || sz == 0) age = 0;
        else if (age < MAX_WAIT) age = age + 1;
        if (slot) begin
            foreach (mq[i]) if (mq[i].r == preg) mq[i].live = 1'b0;
        end
        if (popIt) void'(mq.pop_front());
        if (mv && e.rdy && mreg != 0) mq.push_back('{mreg, mdata, 1'b1});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic resetChk(input string tag);
        chk({tag, "_pending"}, 64'(pending_cnt), 64'd0);
        chk({tag, "_ready"}, 64'(md_ready), 64'd1);
        chk({tag, "_rf_we"}, 64'(rf_we), 64'd0);
        chk({tag, "_stall"}, 64'(stall_pipe), 64'd0);
        chk({tag, "_hazard"}, 64'(hazard), 64'd0);
    endtask

    // Assert reset between edges and check the asynchronous clear.
    task automatic midReset();
        @(posedge clock);
        #1;
        pipe_we = 0; pipe_reg = 0; pipe_data = 0;
        md_valid = 0; md_reg = 0; md_data = 0;
        rs_a = 13; rs_b = 14;
        reset_n = 1'b0;
        #1;
        resetChk("t1_async");
        mq.delete();
        age = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        rs_a = 0; rs_b = 0;
        reset_n = 1'b1;
    endtask

    initial begin
        #2;
        resetChk("reset");
        @(negedge clock);
        reset_n = 1'b1;

        // T2: free port, single result drains the next cycle
        cyc(0, 0, 0, 1, 5'd5, 32'h1234, 0, 0);
        idle(2);

        // T3: continuous pipe writes starve r7 until a bubble
        cyc(1, 5'd3, 32'h3, 1, 5'd7, 32'h77, 0, 0);
        cyc(1, 5'd4, 32'h4, 0, 0, 0, 0, 0);
        cyc(1, 5'd6, 32'h6, 0, 0, 0, 0, 0);
        cyc(1, 5'd8, 32'h8, 0, 0, 0, 0, 0);
        cyc(1, 5'd10, 32'hA, 0, 0, 0, 0, 0);
        cyc(1, 5'd11, 32'hB, 0, 0, 0, 0, 0);
        #1 chk("t3_stall_raised", 64'(stall_pipe), 64'd1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("t3_r7_written", 64'(rf_reg), 64'd7);
        idle(2);

        // T4: fill under pipe pressure, third result held until a pop
        cyc(1, 5'd1, 32'h11, 1, 5'd13, 32'hD0, 0, 0);
        cyc(1, 5'd2, 32'h12, 1, 5'd14, 32'hE0, 0, 0);
        cyc(1, 5'd3, 32'h13, 1, 5'd15, 32'hF0, 0, 0);
        #1 chk("t4_full_ready", 64'(md_ready), 64'd0);
        cyc(1, 5'd4, 32'h14, 1, 5'd15, 32'hF0, 0, 0);
        cyc(0, 0, 0, 1, 5'd15, 32'hF0, 0, 0);
        cyc(0, 0, 0, 1, 5'd15, 32'hF0, 0, 0);
        idle(3);

        // T1: reset while two results are buffered
        cyc(1, 5'd1, 32'h21, 1, 5'd13, 32'hD1, 0, 0);
        cyc(1, 5'd2, 32'h22, 1, 5'd14, 32'hE1, 0, 0);
        cyc(1, 5'd3, 32'h23, 0, 0, 0, 0, 0);
        midReset();
        idle(3);

        // T5: WAW squash of buffered r9
        cyc(1, 5'd1, 32'h31, 1, 5'd9, 32'hAA, 0, 0);
        cyc(1, 5'd9, 32'hBB, 0, 0, 0, 5'd9, 0);
        cyc(0, 0, 0, 0, 0, 0, 5'd9, 0);
        #1 chk("t5_hazard_dropped", 64'(hazard), 64'd0);
        idle(2);

        // T6: r0 result discarded; hazard on rs_b
        cyc(0, 0, 0, 1, 5'd0, 32'h55, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 5'd1, 32'h41, 1, 5'd12, 32'hC0, 0, 0);
        cyc(1, 5'd2, 32'h42, 0, 0, 0, 0, 5'd12);
        #1 chk("t6_hazard_rs_b", 64'(hazard), 64'd1);
        idle(2);

        // Same-cycle push and pipe write to one register: younger survives
        cyc(1, 5'd6, 32'h61, 1, 5'd6, 32'h66, 0, 0);
        idle(2);

        // Random traffic with alternating pipe pressure
        for (int n = 0; n < 800; n++) begin
            int thr;
            thr = ((n % 200) < 100) ? 5 : 9;
            cyc($urandom_range(0, 9) < thr, 5'($urandom_range(0, 15)),
                $urandom, $urandom_range(0, 9) < 4,
                5'($urandom_range(0, 15)), $urandom,
                5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
        end
        idle(8);

        @(negedge clock);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
